otter_rf_write_arbiter: RTL
===========================

# otter_rf_write_arbiter

Shares the single write port of the OTTER 32×32 register file among several writeback sources, such as the ALU/immediate path, the multi-cycle memory load path and the CSR/mult unit. It performs round-robin arbitration with a valid/ready handshake and registers the winning write onto the register-file write port. It also keeps a pending-write scoreboard so the multicycle control FSM can stall reads of registers whose writes have not yet landed.

## Interface
- NUM_REQ, 3, number of writeback requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- clock  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has a write pending
- req_addr  in  NUM_REQ×ADDR_W  destination register of requester i
- req_data  in  NUM_REQ×DATA_W  write data of requester i
- req_ready  out  NUM_REQ  one-hot or zero; grant to requester i this cycle
- resv_valid  in  1  reserve destination register (issued instruction will write it)
- resv_addr  in  ADDR_W  register being reserved
- rf_we  out  1  register-file write enable (RegWrite)
- rf_wa  out  ADDR_W  register-file write address
- rf_wd  out  DATA_W  register-file write data
- pending  out  2^ADDR_W  bit r = 1 while register r has a reserved, not-yet-written value

## Operation
- Clock and reset: one clock (`clock`); reset (`reset_n`) is asynchronous and active-low.
- Round-robin grant:
  - Priority search starts at (last_grant+1) mod NUM_REQ.
  - The first requester with req_valid=1 gets req_ready=1. At most one ready per cycle.
  - req_ready is combinational from req_valid and last_grant.
- Transfer: a write transfers when req_valid[i] & req_ready[i].
  - last_grant updates to i on transfer.
  - With no transfer, last_grant holds.
- Requester obligations:
  - Hold valid, addr and data stable until ready.
  - Valid must not drop before the transfer.
- Write register:
  - On transfer, rf_we <= (addr != 0), rf_wa <= addr, rf_wd <= data.
  - With no transfer, rf_we <= 0; rf_wa/rf_wd hold.
  - A write to x0 is accepted (ready given, scoreboard untouched) but never reaches the register file.
- Scoreboard set: resv_valid with resv_addr != 0 sets pending[resv_addr]. Reserving x0 is ignored; pending[0] is constant 0.
- Scoreboard clear: a transfer to address r clears pending[r] at the same edge rf_we rises.
- Set and clear to the same register in the same cycle: set wins, so pending stays 1 (the new producer).
- Transfer to a non-pending register: allowed, no error. Reserving an already-pending register: no change.

## Timing
- Reset values:
  - rf_we=0, rf_wa=0, rf_wd=0.
  - pending=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - req_ready is 0 for all since all valids are 0 after reset.
- Latency: transfer in cycle N gives rf_we/rf_wa/rf_wd valid in cycle N+1. The register file captures at the end of N+1.
- pending[r] falls in cycle N+1, together with rf_we. A read of r in N+1 sees the old RF value; consumers wait until pending[r]=0 and one further edge.
- Throughput: one write per cycle.
- Fairness: with all requesters continuously valid, each is granted once every NUM_REQ cycles.
- Reset mid-operation:
  - Outputs clear immediately (asynchronous).
  - An in-flight registered write is dropped, as is all pending state.
  - Requesters re-arbitrate from requester 0.

## Structure
- Package otter_rf_pkg: ADDR_W, DATA_W, NUM_REGS=32, typedef rf_addr_t, typedef rf_data_t, typedef rf_wr_t struct {we, wa, wd}.
- Sub-module otter_rr_arbiter: parameter N; inputs clock, reset_n, req[N], ack; outputs gnt[N] (one-hot) and the last_grant pointer state.
- The top level holds the write-port register and the scoreboard.

## Test plan
- **Reset then first request:** after reset, req_valid=3'b111 → req_ready=3'b001. Next cycle rf_we=1 with requester 0's addr/data. Then grants 3'b010, 3'b100, 3'b001 on successive cycles.
- **Single write and scoreboard:** resv_valid with addr 5 → pending[5]=1. Requester 1 writes addr 5, data 0xDEADBEEF in cycle N → cycle N+1 shows rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF, pending[5]=0.
- **x0 handling:** resv_addr=0 → pending stays 0. Requester 2 writes addr 0, data 0x1234 → req_ready[2]=1, rf_we stays 0.
- **Set/clear collision:** pending[7]=1; in one cycle, a transfer to addr 7 plus resv_valid with addr 7 → rf_we=1, rf_wa=7 next cycle, and pending[7] remains 1.
- **Stall hold:** requester 0 continuously valid, requester 2 raises valid → requester 2 granted within 2 cycles. Its addr/data are held until ready and written exactly once.
- **Async reset mid-write:** assert reset_n=0 between clock edges while rf_we=1 and pending=0x0000_00A0 → rf_we=0 and pending=0 immediately, without a clock edge.

Source files
------------

// File: rtl/otter_rf_pkg.sv
// Shared types and helpers for the OTTER register-file write path.
//   ADDR_W / DATA_W / NUM_REGS : register-file geometry
//   rf_addr_t / rf_data_t      : address and data words
//   rf_wr_t                    : one register-file write (we, wa, wd)
//   rr_pick                    : round-robin one-hot pick over up to MAX_REQ requesters
package otter_rf_pkg;

   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned NUM_REGS  = 32;
   localparam int unsigned MAX_REQ   = 8;
   localparam int unsigned MAX_REQ_W = 3;

   typedef logic [ADDR_W-1:0] rf_addr_t;
   typedef logic [DATA_W-1:0] rf_data_t;

   typedef struct packed {
      logic     we;
      rf_addr_t wa;
      rf_data_t wd;
   } rf_wr_t;

   // First set bit of req (among the low n bits) searching upward from last+1, wrapping.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input int unsigned        last,
                                                  input int unsigned        n);
      logic [MAX_REQ-1:0] g;
      logic               found;
      int unsigned        idx;
      g     = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_REQ; k++) begin
         if (k <= n) begin
            idx = last + k;
            if (idx >= n) idx = idx - n;
            if (!found && req[idx[MAX_REQ_W-1:0]]) begin
               g[idx[MAX_REQ_W-1:0]] = 1'b1;
               found = 1'b1;
            end
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/otter_rr_arbiter.sv
// Round-robin arbiter with a last-grant pointer.
//   clock, reset_n : clock and asynchronous active-low reset
//   req[N]         : request vector
//   ack            : the granted request transferred this cycle
//   gnt[N]         : one-hot (or zero) grant, combinational from req and the pointer
//   last_grant     : index of the most recent transfer (resets to N-1)
module otter_rr_arbiter #(
   parameter int unsigned N = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [N-1:0]          req,
   input  logic                  ack,
   output logic [N-1:0]          gnt,
   output logic [$clog2(N)-1:0]  last_grant
);
   import otter_rf_pkg::*;

   localparam int unsigned PW = $clog2(N);

   logic [PW-1:0]      last_q;
   logic [PW-1:0]      last_nxt;
   logic [MAX_REQ-1:0] pick;

   // Grant search starts one past the last winner.
   always_comb begin
      pick = rr_pick(MAX_REQ'(req), 32'(last_q), N);
      gnt  = pick[N-1:0];
   end

   // Encode the current grant for the pointer update.
   always_comb begin
      last_nxt = last_q;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt[i]) last_nxt = PW'(i);
      end
   end

   // Pointer moves only on a completed transfer; reset favours requester 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= PW'(N - 1);
      end else if (ack) begin
         last_q <= last_nxt;
      end
   end

   assign last_grant = last_q;

endmodule

// File: rtl/otter_rf_write_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources and tracks
// registers with outstanding writes.
//   clock, reset_n         : clock and asynchronous active-low reset
//   req_valid/addr/data    : per-requester write request (flattened, requester i at slice i)
//   req_ready              : combinational one-hot grant
//   resv_valid/resv_addr   : reserve a destination register at issue
//   rf_we/rf_wa/rf_wd      : registered register-file write port
//   pending                : bit r set while register r awaits its write
module otter_rf_write_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned DATA_W  = otter_rf_pkg::DATA_W,
   parameter int unsigned ADDR_W  = otter_rf_pkg::ADDR_W
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic                        resv_valid,
   input  logic [ADDR_W-1:0]           resv_addr,
   output logic                        rf_we,
   output logic [ADDR_W-1:0]           rf_wa,
   output logic [DATA_W-1:0]           rf_wd,
   output logic [(2**ADDR_W)-1:0]      pending
);
   import otter_rf_pkg::*;

   localparam int unsigned NREGS = 2**ADDR_W;

   logic [NUM_REQ-1:0]         gnt;
   logic                       xfer;
   logic [ADDR_W-1:0]          sel_addr;
   logic [DATA_W-1:0]          sel_data;
   logic [NREGS-1:0]           pending_nxt;
   // Pointer state is kept for debug visibility only.
   logic [$clog2(NUM_REQ)-1:0] last_grant_unused;

   otter_rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .clock      (clock),
      .reset_n    (reset_n),
      .req        (req_valid),
      .ack        (xfer),
      .gnt        (gnt),
      .last_grant (last_grant_unused)
   );

   // The arbiter only grants a valid requester, so any grant is a transfer.
   assign req_ready = gnt;
   assign xfer      = |gnt;

   // Route the winning requester's payload.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Scoreboard update: clear first so a same-cycle reservation (new producer) wins.
   always_comb begin
      pending_nxt = pending;
      if (xfer) pending_nxt[sel_addr] = 1'b0;
      if (resv_valid && (resv_addr != '0)) pending_nxt[resv_addr] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Write-port register and scoreboard; x0 writes are accepted but never enabled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rf_we   <= 1'b0;
         rf_wa   <= '0;
         rf_wd   <= '0;
         pending <= '0;
      end else begin
         rf_we <= xfer && (sel_addr != '0);
         if (xfer) begin
            rf_wa <= sel_addr;
            rf_wd <= sel_data;
         end
         pending <= pending_nxt;
      end
   end

endmodule
